// File: rtl/mem_pkg.sv
// Purpose : shared types and constants for the data-memory access unit.
// Latency : n/a (package only).
// Backpressure: n/a. Contents: FSM state type, funct3 size/sign codes, MAX_WAIT default, helpers.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_WAIT_DEFAULT = 255;

  // funct3 codes: bits [1:0] give the access size, bit 2 selects zero-extension.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // An access is misaligned when the address is not a multiple of its size.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = off[0];
      2'd2:    misaligned = |off[1:0];
      default: misaligned = |off;
    endcase
  endfunction

  // Byte-strobe pattern for an access of the given size at offset 0.
  function automatic logic [7:0] strb_base(input logic [1:0] size);
    case (size)
      2'd0:    strb_base = 8'h01;
      2'd1:    strb_base = 8'h03;
      2'd2:    strb_base = 8'h0F;
      default: strb_base = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Purpose : extract the addressed bytes of a 64-bit memory word and sign/zero-extend them.
// Latency : combinational. Backpressure: none.
// Ports   : rdata (raw doubleword), off (byte offset), funct3 (size/sign) -> data (formatted load).
module load_align
  import mem_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  off,
  input  logic [2:0]  funct3,
  output logic [63:0] data
);

  logic [63:0] sh;

  always_comb begin
    sh = rdata >> {off, 3'b000};
    case (funct3)
      F3_B:    data = {{56{sh[7]}},  sh[7:0]};
      F3_H:    data = {{48{sh[15]}}, sh[15:0]};
      F3_W:    data = {{32{sh[31]}}, sh[31:0]};
      F3_BU:   data = {56'd0, sh[7:0]};
      F3_HU:   data = {48'd0, sh[15:0]};
      F3_WU:   data = {32'd0, sh[31:0]};
      default: data = sh;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Purpose : MEM-stage data-memory access unit: aligns loads/stores, handshakes with memory, flags errors.
// Latency : non-memory ops pass through combinationally; memory ops stall >=1 REQ cycle then 1 DONE cycle.
// Backpressure: stall freezes the pipeline while a request waits for mem_ack (bounded by MAX_WAIT).
// Ports   : EX_MEM inputs (ALU_data, store_data, controls, funct3); MEM_WB outputs (rd_data, ALU_data_out,
//           MemtoReg_out, regwrite_out); stall; memory request/response; misalign_err/bus_err pulses.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] ALU_data,
  input  logic [63:0] store_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemtoReg,
  input  logic        regwrite,
  input  logic [2:0]  funct3,
  output logic [63:0] rd_data,
  output logic [63:0] ALU_data_out,
  output logic        MemtoReg_out,
  output logic        regwrite_out,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  state_t      state, nxt;
  logic [CW-1:0] cnt;
  logic [63:0] cap_addr, cap_data, rd_reg, load_data;
  logic [2:0]  cap_f3;
  logic        cap_we, cap_memtoreg, cap_regwrite;
  logic        mem_op, mis, start, timeout;

  assign mem_op  = MemRead | MemWrite;
  assign mis     = misaligned(funct3[1:0], ALU_data[2:0]);
  assign start   = (state == IDLE) && mem_op && !mis;
  // An ack on the final wait cycle wins over the timeout.
  assign timeout = (state == REQ) && !mem_ack && (cnt == CW'(MAX_WAIT - 1));

  load_align u_load_align (
    .rdata  (mem_rdata),
    .off    (cap_addr[2:0]),
    .funct3 (cap_f3),
    .data   (load_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = REQ;
      REQ:     if (mem_ack || timeout) nxt = DONE;
      DONE:    nxt = IDLE;  // pipeline advances this cycle, so the held op is not reissued
      default: nxt = IDLE;
    endcase
  end

  // Captured request, wait counter, load result and error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      rd_reg       <= '0;
      bus_err      <= 1'b0;
      misalign_err <= 1'b0;
      cap_addr     <= '0;
      cap_data     <= '0;
      cap_f3       <= '0;
      cap_we       <= 1'b0;
      cap_memtoreg <= 1'b0;
      cap_regwrite <= 1'b0;
    end else begin
      bus_err      <= timeout;
      misalign_err <= (state == IDLE) && mem_op && mis;
      if (start) begin
        cnt          <= '0;
        cap_addr     <= ALU_data;
        cap_data     <= store_data;
        cap_f3       <= funct3;
        cap_we       <= MemWrite;
        cap_memtoreg <= MemtoReg;
        cap_regwrite <= regwrite;
      end
      if (state == REQ) begin
        cnt <= cnt + CW'(1);
        if (mem_ack)      rd_reg <= cap_we ? 64'd0 : load_data;
        else if (timeout) rd_reg <= 64'd0;
      end
    end
  end

  // Outputs
  always_comb begin
    stall        = 1'b0;
    rd_data      = 64'd0;
    ALU_data_out = ALU_data;
    MemtoReg_out = MemtoReg;
    regwrite_out = regwrite;
    mem_req      = (state == REQ);
    mem_we       = cap_we;
    mem_addr     = {cap_addr[63:3], 3'b000};
    mem_wdata    = cap_data << {cap_addr[2:0], 3'b000};
    mem_wstrb    = cap_we ? (strb_base(cap_f3[1:0]) << cap_addr[2:0]) : 8'h00;
    case (state)
      IDLE: begin
        if (mem_op) begin
          if (mis) regwrite_out = 1'b0;
          else     stall        = 1'b1;
        end
      end
      REQ: begin
        stall        = 1'b1;
        ALU_data_out = cap_addr;
        MemtoReg_out = cap_memtoreg;
        regwrite_out = cap_regwrite;
      end
      DONE: begin
        rd_data      = rd_reg;
        ALU_data_out = cap_addr;
        MemtoReg_out = cap_memtoreg;
        // bus_err is high exactly during the DONE cycle that follows a timeout
        regwrite_out = cap_regwrite & ~bus_err;
      end
      default: ;
    endcase
  end

endmodule
